// File: rtl/memlibc_bist_seq_pkg.sv
// Shared state type and default sizing for the memory BIST sequencer.
package memlibc_bist_seq_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLaunch  = 3'd1,
    StWait    = 3'd2,
    StRelease = 3'd3,
    StDone    = 3'd4
  } seq_state_e;

  localparam int unsigned NUM_CTRL_DEF = 4;
  localparam int unsigned TIMEOUT_DEF  = 65535;
  localparam int unsigned TMR_W_DEF    = 16;

endpackage

// File: rtl/memlibc_memory_bist_assembly_rtl_tessent_bist_timer.sv
// WAIT-phase watchdog: cleared on launch, counts while enabled, flags the last allowed cycle.
module memlibc_memory_bist_assembly_rtl_tessent_bist_timer
  import memlibc_bist_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned TMR_W   = TMR_W_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == TMR_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/blk_c4fa39.sv
// Sequential launcher for an assembly's memory BIST controllers, one controller at a time.
// Define MEMLIBC_BIST_SEQ_TIMEOUT_EN to build the per-controller hang timeout.
module blk_c4fa39
  import memlibc_bist_seq_pkg::*;
#(
  parameter int unsigned NUM_CTRL = NUM_CTRL_DEF,
  parameter int unsigned IDX_W    = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
  parameter int unsigned TMR_W    = TMR_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  output logic [NUM_CTRL-1:0] ctrl_run_o,
  input  logic [NUM_CTRL-1:0] ctrl_done_i,
  input  logic [NUM_CTRL-1:0] ctrl_go_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                go_o,
  output logic [NUM_CTRL-1:0] fail_vec_o,
  output logic                timeout_o,
  output logic [IDX_W-1:0]    cur_idx_o
);

  if (NUM_CTRL < 1 || NUM_CTRL > 16) begin : g_chk_num
    $error("NUM_CTRL must be in 1..16");
  end
  if (TIMEOUT == 0 || 64'(TIMEOUT) >= (64'd1 << TMR_W)) begin : g_chk_tmo
    $error("TIMEOUT must be in 1..2**TMR_W-1");
  end

  seq_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_CTRL-1:0] run_q, run_d, fail_q, fail_d;
  logic                busy_q, busy_d, done_q, done_d, go_q, go_d;
  logic                done_sel, last_idx, rel_ok;
  logic [NUM_CTRL-1:0] run_sel;

  assign done_sel = ctrl_done_i[idx_q];
  assign last_idx = (idx_q == IDX_W'(NUM_CTRL - 1));
  assign run_sel  = NUM_CTRL'(1) << idx_q;

`ifdef MEMLIBC_BIST_SEQ_TIMEOUT_EN
  logic expired, timeout_q, timeout_d, hung_q, hung_d;

  memlibc_memory_bist_assembly_rtl_tessent_bist_timer #(
    .TIMEOUT(TIMEOUT),
    .TMR_W  (TMR_W)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (state_q == StLaunch),
    .enable_i (state_q == StWait),
    .expired_o(expired)
  );

  // A hung controller may never return done to zero, so it skips the release wait.
  assign rel_ok    = hung_q | ~done_sel;
  assign timeout_o = timeout_q;
`else
  assign rel_ok    = ~done_sel;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    run_d   = run_q;
    fail_d  = fail_q;
    done_d  = done_q;
    go_d    = go_q;
`ifdef MEMLIBC_BIST_SEQ_TIMEOUT_EN
    timeout_d = timeout_q;
    hung_d    = hung_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StLaunch;
          idx_d   = '0;
          fail_d  = '0;
          done_d  = 1'b0;
          go_d    = 1'b0;
`ifdef MEMLIBC_BIST_SEQ_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      StLaunch: begin
        if (!start_i) begin
          state_d = StIdle;
          run_d   = '0;
        end else begin
          state_d = StWait;
          run_d   = run_sel;
`ifdef MEMLIBC_BIST_SEQ_TIMEOUT_EN
          hung_d = 1'b0;
`endif
        end
      end
      StWait: begin
        if (!start_i) begin
          state_d = StIdle;
          run_d   = '0;
        end else if (done_sel) begin
          fail_d[idx_q] = ~ctrl_go_i[idx_q];
          run_d         = '0;
          state_d       = StRelease;
        end
`ifdef MEMLIBC_BIST_SEQ_TIMEOUT_EN
        else if (expired) begin
          fail_d[idx_q] = 1'b1;
          timeout_d     = 1'b1;
          hung_d        = 1'b1;
          run_d         = '0;
          state_d       = StRelease;
        end
`endif
      end
      StRelease: begin
        if (!start_i) begin
          state_d = StIdle;
          run_d   = '0;
        end else if (rel_ok) begin
          if (last_idx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StLaunch;
          end
        end
      end
      StDone: begin
        done_d = 1'b1;
        go_d   = ~|fail_q;
        if (!start_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        run_d   = '0;
      end
    endcase
    busy_d = (state_d == StLaunch) || (state_d == StWait) || (state_d == StRelease);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      run_q   <= '0;
      fail_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      go_q    <= go_d;
    end
  end

`ifdef MEMLIBC_BIST_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      timeout_q <= 1'b0;
      hung_q    <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
      hung_q    <= hung_d;
    end
  end
`endif

  assign ctrl_run_o = run_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign go_o       = go_q;
  assign fail_vec_o = fail_q;
  assign cur_idx_o  = idx_q;

endmodule

// File: tb/tb_blk_c4fa39.sv
// Bench for blk_c4fa39: emulated BIST controllers plus an outcome model per sequence run.
`timescale 1ns/1ps
module tb_blk_c4fa39;

  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 16;
`ifdef MEMLIBC_BIST_SEQ_TIMEOUT_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         start_i = 1'b0;
  logic [N-1:0] ctrl_run_o;
  logic [N-1:0] ctrl_done_i;
  logic [N-1:0] ctrl_go_i;
  logic         busy_o, done_o, go_o, timeout_o;
  logic [N-1:0] fail_vec_o;
  logic [1:0]   cur_idx_o;

  int nchk = 0;
  int nbad = 0;

  // Controller behaviour: done after dly run cycles, go=gob, done dropped rel cycles after run.
  int dly[N];
  int rel[N];
  bit gob[N];
  bit hang[N];
  int cnt[N]    = '{default: 0};
  int relc[N]   = '{default: 0};
  int run_hi[N] = '{default: 0};
  logic [N-1:0] done_r   = '0;
  logic [N-1:0] go_r     = '0;
  logic [N-1:0] prev_run = '0;
  int order_q[$];

  assign ctrl_done_i = done_r;
  assign ctrl_go_i   = go_r;

  always #5 clk_i = ~clk_i;

  blk_c4fa39 #(
    .NUM_CTRL(N),
    .TIMEOUT (TMO),
    .TMR_W   (16)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .ctrl_run_o (ctrl_run_o),
    .ctrl_done_i(ctrl_done_i),
    .ctrl_go_i  (ctrl_go_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .go_o       (go_o),
    .fail_vec_o (fail_vec_o),
    .timeout_o  (timeout_o),
    .cur_idx_o  (cur_idx_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i) begin
    check("run_onehot", 32'($onehot0(ctrl_run_o)), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (ctrl_run_o[i]) begin
        run_hi[i]++;
        if (!prev_run[i]) begin
          order_q.push_back(i);
          check("launch_rtz", 32'(done_r), 32'd0);
        end
      end
    end
    prev_run = ctrl_run_o;
    for (int i = 0; i < N; i++) begin
      if (ctrl_run_o[i]) begin
        relc[i] = 0;
        if (!done_r[i]) begin
          cnt[i]++;
          if (!hang[i] && cnt[i] >= dly[i]) done_r[i] = 1'b1;
        end
      end else begin
        cnt[i] = 0;
        if (done_r[i]) begin
          relc[i]++;
          if (relc[i] >= rel[i]) done_r[i] = 1'b0;
        end
      end
      go_r[i] = done_r[i] ? gob[i] : 1'($urandom);
    end
  end

  task automatic set_all(input int d, input bit g, input int rl);
    for (int i = 0; i < N; i++) begin
      dly[i] = d; gob[i] = g; rel[i] = rl; hang[i] = 1'b0;
    end
  endtask

  task automatic settle();
    for (int k = 0; k < 50 && done_r != '0; k++) @(negedge clk_i);
    check("settle", 32'(ctrl_done_i), 32'd0);
  endtask

  task automatic wait_run(input int idx, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 500 && !seen; k++) begin
      @(negedge clk_i);
      seen = ctrl_run_o[idx];
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // Full pass through all controllers; expectations come from the controller settings.
  task automatic do_run(input string tag);
    logic [N-1:0] ef;
    logic         et;
    int           code;
    bit           seen;
    ef = '0;
    et = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (hang[i] || (TE && dly[i] > int'(TMO))) begin
        ef[i] = 1'b1;
        et    = 1'b1;
      end else begin
        ef[i] = ~gob[i];
      end
    end
    settle();
    order_q.delete();
    for (int i = 0; i < N; i++) run_hi[i] = 0;
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    check({tag, ".l1_run"}, 32'(ctrl_run_o), 32'd0);
    check({tag, ".l1_clr"}, {fail_vec_o, done_o, go_o, timeout_o, cur_idx_o}, 32'd0);
    check({tag, ".l1_busy"}, 32'(busy_o), 32'd1);
    @(posedge clk_i); #1;
    check({tag, ".l2_run"}, 32'(ctrl_run_o), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk_i);
      seen = done_o;
    end
    check({tag, ".done"}, 32'(done_o), 32'd1);
    check({tag, ".go"}, 32'(go_o), 32'(~|ef));
    check({tag, ".fail"}, 32'(fail_vec_o), 32'(ef));
    check({tag, ".tmo"}, 32'(timeout_o), 32'(et));
    check({tag, ".idx"}, 32'(cur_idx_o), N - 1);
    check({tag, ".busy"}, 32'(busy_o), 32'd0);
    code = 0;
    foreach (order_q[k]) code |= order_q[k] << (4 * k);
    check({tag, ".order"}, code, 32'h3210);
    start_i = 1'b0;
    @(negedge clk_i);
    check({tag, ".hold"}, {done_o, go_o, fail_vec_o, busy_o}, {1'b1, ~|ef, ef, 1'b0});
  endtask

  initial begin
    set_all(5, 1'b1, 1);
    repeat (2) @(negedge clk_i);
    check("rst_run", 32'(ctrl_run_o), 32'd0);
    check("rst_flags", {busy_o, done_o, go_o, timeout_o}, 32'd0);
    check("rst_fail", 32'(fail_vec_o), 32'd0);
    check("rst_idx", 32'(cur_idx_o), 32'd0);
    rst_ni = 1'b1;

    do_run("pass");
    gob[2] = 1'b0;
    do_run("fail2");
    gob[2] = 1'b1;
    dly[1] = 16;
    do_run("edge16");
    dly[1] = 5;
    dly[3] = 17;
    do_run("edge17");
    dly[3] = 5;
    rel[0] = 10;
    do_run("hold10");
    rel[0] = 1;

    hang[1] = 1'b1;
`ifdef MEMLIBC_BIST_SEQ_TIMEOUT_EN
    do_run("hang");
    check("hang.run_cycles", run_hi[1], TMO);
`else
    settle();
    @(negedge clk_i);
    start_i = 1'b1;
    wait_run(1, "hang.launch");
    repeat (100) @(negedge clk_i);
    check("hang.busy", 32'(busy_o), 32'd1);
    check("hang.run", 32'(ctrl_run_o), 32'b0010);
    start_i = 1'b0;
    @(posedge clk_i); #1;
    check("hang.abort", {ctrl_run_o, busy_o}, 32'd0);
`endif
    hang[1] = 1'b0;

    // Abort during controller 2's WAIT keeps the partial fail vector.
    set_all(8, 1'b1, 1);
    gob[1] = 1'b0;
    settle();
    @(negedge clk_i);
    start_i = 1'b1;
    wait_run(2, "abort.launch");
    repeat (3) @(negedge clk_i);
    start_i = 1'b0;
    @(posedge clk_i); #1;
    check("abort.run", 32'(ctrl_run_o), 32'd0);
    check("abort.flags", {busy_o, done_o}, 32'd0);
    check("abort.fail", 32'(fail_vec_o), 32'b0010);
    do_run("rerun");

    // Synchronous reset in the middle of controller 1's WAIT.
    set_all(6, 1'b1, 1);
    gob[0] = 1'b0;
    settle();
    @(negedge clk_i);
    start_i = 1'b1;
    wait_run(1, "mrst.launch");
    repeat (2) @(negedge clk_i);
    check("mrst.pre_fail", 32'(fail_vec_o), 32'b0001);
    rst_ni  = 1'b0;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    check("mrst.run", 32'(ctrl_run_o), 32'd0);
    check("mrst.flags", {busy_o, done_o, go_o, timeout_o}, 32'd0);
    check("mrst.fail", 32'(fail_vec_o), 32'd0);
    check("mrst.idx", 32'(cur_idx_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        dly[i]  = $urandom_range(1, TE ? 20 : 12);
        gob[i]  = 1'($urandom_range(0, 1));
        rel[i]  = $urandom_range(1, 3);
        hang[i] = 1'b0;
      end
      do_run($sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule

// File: doc/blk_c4fa39.md
Name: memlibc_memory_bist_assembly_rtl_tessent_bist_sequencer

Overview:
- Sequential launcher for the memory BIST controllers of one assembly. It sits upstream of the assembly's and2 go/done reduction cells.
- Starts each controller in turn and captures its done/go handshake.
- Drives a sticky per-controller fail vector, plus aggregated done_o/go_o consumed by the and2 reduction tree.
- One controller runs at a time, which bounds peak test power.

Parameters:
- NUM_CTRL, 4, number of BIST controllers sequenced (1..16).
- IDX_W, $clog2(NUM_CTRL) (min 1), width of the controller index.
- TIMEOUT, 65535, maximum WAIT cycles per controller before it is declared hung.
- TMR_W, 16, width of the timeout counter; TIMEOUT must be < 2**TMR_W.

Ports:
- clk_i  in  1  BIST clock.
- rst_ni  in  1  reset; synchronous, active-low.
- start_i  in  1  level request. Rising while IDLE starts a run; dropping mid-run aborts it.
- ctrl_run_o  out  NUM_CTRL  one-hot run request to controller i.
- ctrl_done_i  in  NUM_CTRL  controller i finished; held high until its run drops.
- ctrl_go_i  in  NUM_CTRL  controller i pass flag; valid while ctrl_done_i[i]=1.
- busy_o  out  1  sequence in progress.
- done_o  out  1  all controllers completed (sticky until next start).
- go_o  out  1  all controllers passed; valid when done_o=1.
- fail_vec_o  out  NUM_CTRL  sticky per-controller fail (fail = no go, or timeout).
- timeout_o  out  1  sticky: at least one controller timed out.
- cur_idx_o  out  IDX_W  index of the controller currently launched.

Behaviour:
- Clock and reset: single clock clk_i. rst_ni is synchronous and active-low.
- Reset values: state=IDLE, cur_idx=0, every output 0.
- States are IDLE, LAUNCH, WAIT, RELEASE, DONE.
- IDLE:
  - start_i=1 -> LAUNCH.
  - The same edge clears fail_vec_o, timeout_o, done_o and go_o, and sets cur_idx=0.
- LAUNCH (1 cycle):
  - ctrl_run_o[cur_idx] is registered high and stays high through WAIT.
  - Timer cleared to 0. Next state is WAIT.
- WAIT:
  - Timer increments each cycle.
  - ctrl_done_i[cur_idx]=1:
    - fail_vec[cur_idx] <= ~ctrl_go_i[cur_idx].
    - ctrl_run_o drops next cycle.
    - Next state is RELEASE.
  - Timer==TIMEOUT-1 with done still low:
    - fail_vec[cur_idx] <= 1 and timeout_o <= 1.
    - ctrl_run_o drops. Next state is RELEASE.
  - If done and timeout occur in the same cycle, done wins: the go flag is captured and timeout_o is not set.
  - done/go of non-selected controllers are ignored.
- RELEASE:
  - Waits for ctrl_done_i[cur_idx]=0 (return-to-zero). A timed-out controller skips the wait.
  - If cur_idx==NUM_CTRL-1 -> DONE. Otherwise cur_idx++ -> LAUNCH.
- DONE:
  - done_o <= 1 and go_o <= ~|fail_vec.
  - start_i=0 -> IDLE. done_o, go_o, fail_vec_o and timeout_o hold until the next start.
- busy_o = state in {LAUNCH, WAIT, RELEASE}, registered.
- Abort: start_i=0 in LAUNCH, WAIT or RELEASE:
  - All ctrl_run_o go to 0 next cycle.
  - State goes to IDLE; done_o stays 0 and fail_vec_o keeps its partial result.
- Latency: start to first run is 2 cycles. A controller with done delay d and immediate release costs d+3 cycles.
- cur_idx never wraps: it saturates at NUM_CTRL-1 and is reset on start.
- At most one ctrl_run_o bit is high at any time.

Optional Feature:
- MEMLIBC_BIST_SEQ_TIMEOUT_EN defined: timer and timeout path present as above.
- Undefined:
  - No timer is built; WAIT lasts until done.
  - timeout_o is tied 0; TIMEOUT and TMR_W are unused.

Decomposition:
- Package memlibc_bist_seq_pkg holds:
  - the state enum seq_state_e (IDLE, LAUNCH, WAIT, RELEASE, DONE);
  - default constants NUM_CTRL_DEF and TIMEOUT_DEF.
- One sub-module, memlibc_memory_bist_assembly_rtl_tessent_bist_timer:
  - ports: clear, enable, expired;
  - instantiated only under MEMLIBC_BIST_SEQ_TIMEOUT_EN.

Test Plan (NUM_CTRL=4, TIMEOUT=16):
- Pass path:
  - Stimulus: all controllers assert done with go=1 at 5 cycles, release 1 cycle after run drops.
  - Required: run bits 0001, 0010, 0100, 1000 in order; done_o=1, go_o=1, fail_vec_o=0000.
- Single failure: controller 2 returns go=0 -> fail_vec_o=0100, go_o=0, done_o=1, timeout_o=0.
- Hang (macro on): controller 1 never asserts done.
  - run[1] drops after 16 WAIT cycles; fail_vec_o=0010; timeout_o=1; the sequence completes with go_o=0.
  - With the macro off, busy_o stays 1 indefinitely.
- Abort: drop start_i during controller 2's WAIT.
  - ctrl_run_o=0000 next cycle, state IDLE, done_o=0, busy_o=0.
  - Re-raising start_i clears fail_vec_o and runs from index 0.
- Boundary: done at exactly WAIT cycle 16 (same cycle as expiry) -> go is captured and timeout_o=0. Separately, done held high 10 cycles -> next launch waits for done to fall.
- Reset mid-run: rst_ni=0 for one clock during WAIT -> all outputs 0 at the next edge, state IDLE, cur_idx_o=0.
